key_event_arbiter: RTL and testbench

- Sits downstream of NumKeys debouncer instances.
- Turns each key's debounced level and rising-edge tick into PRESS, RELEASE and LONG events.
- Holds events as per-key pending flags and round-robin arbitrates them onto one valid/ready event channel consumed by the system controller.
- Flags overruns when a key produces an event faster than the consumer drains it.

---
 rtl/key_event_pkg.sv | 24 ++
 rtl/key_event_arbiter_if.sv | 21 ++
 rtl/key_event_fsm.sv | 105 ++++++++++
 rtl/key_event_arbiter.sv | 132 +++++++++++++
 tb/tb_key_event_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event arbiter.
//   evt_type_e  - event code driven on evt_type_o
//   key_state_e - per-key FSM state
//   hold_cycles - converts a clock rate (Hz) and hold time (ms) into cycles
package key_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2
    } evt_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_e;

    function automatic int unsigned hold_cycles(input int unsigned clk_rate,
                                                input int unsigned hold_ms);
        return (clk_rate / 1000) * hold_ms;
    endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if: valid/ready event channel towards the system controller.
//   evt_valid_o - event available (producer)
//   evt_ready_i - consumer accepts when high together with evt_valid_o
//   evt_key_o   - key index of the event
//   evt_type_o  - event code (see key_event_pkg::evt_type_e)
// Modports: master = event producer (arbiter), slave = consumer.
interface key_event_arbiter_if #(
    parameter int unsigned NumKeys = 4
);
    localparam int unsigned KeyW = $clog2(NumKeys);

    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [KeyW-1:0] evt_key_o;
    logic [1:0]      evt_type_o;

    modport master (output evt_valid_o, output evt_key_o, output evt_type_o,
                    input  evt_ready_i);
    modport slave  (input  evt_valid_o, input  evt_key_o, input  evt_type_o,
                    output evt_ready_i);
endinterface

// File: rtl/key_event_fsm.sv
// key_event_fsm: per-key press/release/long detector.
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   level_i, tick_i   - debounced level and its rising-edge pulse
//   set_press_o       - one-cycle pulse: key entered PRESSED
//   set_long_o        - one-cycle pulse: key held long enough (LONG_PRESS_EN only)
//   set_release_o     - one-cycle pulse: key returned to IDLE
// Build option LONG_PRESS_EN adds the HELD state and the hold counter;
// without it set_long_o is tied low.
// The set pulses are registered so they appear the cycle after the
// transition condition is sampled.
module key_event_fsm
    import key_event_pkg::*;
`ifdef LONG_PRESS_EN
#(
    parameter int unsigned HoldCycles = 20
)
`endif
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    input  logic tick_i,
    output logic set_press_o,
    output logic set_long_o,
    output logic set_release_o
);

    key_state_e r_state, w_state_n;
    logic r_set_press, r_set_long, r_set_release;
    logic w_press_n, w_long_n, w_release_n;

`ifdef LONG_PRESS_EN
    localparam int unsigned CntW = $clog2(HoldCycles);
    logic [CntW-1:0] r_cnt, w_cnt_n;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_press_n   = 1'b0;
        w_long_n    = 1'b0;
        w_release_n = 1'b0;
`ifdef LONG_PRESS_EN
        w_cnt_n     = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                // A high level without a tick (held through reset) stays here.
                if (tick_i) begin
                    w_state_n = PRESSED;
                    w_press_n = 1'b1;
`ifdef LONG_PRESS_EN
                    w_cnt_n   = '0;
`endif
                end
            end
            PRESSED: begin
                // Release beats reaching the hold count.
                if (!level_i) begin
                    w_state_n   = IDLE;
                    w_release_n = 1'b1;
                end
`ifdef LONG_PRESS_EN
                else if (r_cnt == CntW'(HoldCycles - 1)) begin
                    w_state_n = HELD;
                    w_long_n  = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + CntW'(1);
                end
`endif
            end
            HELD: begin
                if (!level_i) begin
                    w_state_n   = IDLE;
                    w_release_n = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_set_press   <= 1'b0;
            r_set_long    <= 1'b0;
            r_set_release <= 1'b0;
`ifdef LONG_PRESS_EN
            r_cnt         <= '0;
`endif
        end else begin
            r_state       <= w_state_n;
            r_set_press   <= w_press_n;
            r_set_long    <= w_long_n;
            r_set_release <= w_release_n;
`ifdef LONG_PRESS_EN
            r_cnt         <= w_cnt_n;
`endif
        end
    end

    assign set_press_o   = r_set_press;
    assign set_long_o    = r_set_long;
    assign set_release_o = r_set_release;

endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: turns NumKeys debounced keys into PRESS/RELEASE/LONG
// events and round-robins them onto one valid/ready channel.
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   db_level_i     - debounced level per key
//   db_tick_i      - debounced 0->1 pulse per key
//   evt            - event channel (key_event_arbiter_if.master)
//   overrun_o      - sticky per-key overrun (event raised while same one pending)
//   clr_overrun_i  - pulse clearing overrun_o (a simultaneous overrun wins)
// Build option LONG_PRESS_EN enables LONG events; otherwise HoldMs is unused
// apart from the elaboration sanity check.
module key_event_arbiter
    import key_event_pkg::*;
#(
    parameter int unsigned NumKeys = 4,
    parameter int unsigned ClkRate = 10_000_000,
    parameter int unsigned HoldMs  = 500
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumKeys-1:0]    db_level_i,
    input  logic [NumKeys-1:0]    db_tick_i,
    key_event_arbiter_if.master   evt,
    output logic [NumKeys-1:0]    overrun_o,
    input  logic                  clr_overrun_i
);

    localparam int unsigned HoldCycles = hold_cycles(ClkRate, HoldMs);
    localparam int unsigned KeyW       = $clog2(NumKeys);

    if (HoldCycles < 2 || NumKeys < 2 || NumKeys > 16) begin : g_bad_cfg
        $error("key_event_arbiter: bad NumKeys or HoldCycles");
    end

    logic [NumKeys-1:0] w_set_press, w_set_long, w_set_release;
    logic [NumKeys-1:0] r_pend_press, r_pend_long, r_pend_release;
    logic [NumKeys-1:0] w_clr_press, w_clr_long, w_clr_release;
    logic [NumKeys-1:0] w_ovr_now, r_ovr;
    logic               r_valid;
    logic [KeyW-1:0]    r_key, r_ptr, w_idx, w_gnt_key, w_ptr_n;
    evt_type_e          r_type, w_gnt_type;
    logic               w_found, w_load;

    for (genvar g = 0; g < NumKeys; g++) begin : g_key
        key_event_fsm
`ifdef LONG_PRESS_EN
            #(.HoldCycles(HoldCycles))
`endif
        u_fsm (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .level_i      (db_level_i[g]),
            .tick_i       (db_tick_i[g]),
            .set_press_o  (w_set_press[g]),
            .set_long_o   (w_set_long[g]),
            .set_release_o(w_set_release[g])
        );
    end

    assign w_load = !r_valid || evt.evt_ready_i;

    // Round-robin search starting at r_ptr; first key with anything pending wins.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_key  = '0;
        w_gnt_type = EVT_PRESS;
        w_idx      = '0;
        for (int unsigned i = 0; i < NumKeys; i++) begin
            w_idx = KeyW'((32'(r_ptr) + i) % NumKeys);
            if (!w_found && (r_pend_press[w_idx] || r_pend_long[w_idx] ||
                             r_pend_release[w_idx])) begin
                w_found   = 1'b1;
                w_gnt_key = w_idx;
                if (r_pend_press[w_idx])     w_gnt_type = EVT_PRESS;
                else if (r_pend_long[w_idx]) w_gnt_type = EVT_LONG;
                else                         w_gnt_type = EVT_RELEASE;
            end
        end
    end

    assign w_ptr_n = (w_gnt_key == KeyW'(NumKeys - 1)) ? '0 : w_gnt_key + KeyW'(1);

    always_comb begin
        w_clr_press   = '0;
        w_clr_long    = '0;
        w_clr_release = '0;
        if (w_load && w_found) begin
            case (w_gnt_type)
                EVT_PRESS:   w_clr_press[w_gnt_key]   = 1'b1;
                EVT_LONG:    w_clr_long[w_gnt_key]    = 1'b1;
                default:     w_clr_release[w_gnt_key] = 1'b1;
            endcase
        end
    end

    // Overrun: a set hits a flag that is still pending after this cycle's grant.
    assign w_ovr_now = (w_set_press   & r_pend_press   & ~w_clr_press)
                     | (w_set_long    & r_pend_long    & ~w_clr_long)
                     | (w_set_release & r_pend_release & ~w_clr_release);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_press   <= '0;
            r_pend_long    <= '0;
            r_pend_release <= '0;
            r_ovr          <= '0;
            r_valid        <= 1'b0;
            r_key          <= '0;
            r_type         <= EVT_PRESS;
            r_ptr          <= '0;
        end else begin
            // Set wins over a same-cycle clear.
            r_pend_press   <= (r_pend_press   & ~w_clr_press)   | w_set_press;
            r_pend_long    <= (r_pend_long    & ~w_clr_long)    | w_set_long;
            r_pend_release <= (r_pend_release & ~w_clr_release) | w_set_release;
            r_ovr          <= (clr_overrun_i ? '0 : r_ovr) | w_ovr_now;
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_key  <= w_gnt_key;
                    r_type <= w_gnt_type;
                    r_ptr  <= w_ptr_n;
                end
            end
        end
    end

    assign evt.evt_valid_o = r_valid;
    assign evt.evt_key_o   = r_key;
    assign evt.evt_type_o  = r_type;
    assign overrun_o       = r_ovr;

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;
    localparam int NK = 4;
    localparam int HC = 20;   // (10_000/1000)*2

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] lvl = '0;
    logic [NK-1:0] tck = '0;
    logic [NK-1:0] ovr;
    logic          clr = 1'b0;
    int            cyc = 0;

    key_event_arbiter_if #(.NumKeys(NK)) evt_if ();

    key_event_arbiter #(.NumKeys(NK), .ClkRate(10_000), .HoldMs(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .db_level_i   (lvl),
        .db_tick_i    (tck),
        .evt          (evt_if),
        .overrun_o    (ovr),
        .clr_overrun_i(clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending flags indexed by priority: 0=press, 1=long, 2=release.
    int   code[3] = '{0, 2, 1};
    bit   m_pend[NK][3];
    bit   m_det[NK][3];      // events detected at the previous edge
    bit   m_down[NK];
    bit   m_long[NK];
    int   m_t0[NK];
    int   m_cyc = 0;
    bit   m_valid = 0;
    int   m_key = 0, m_type = 0, m_ptr = 0;
    logic [NK-1:0] m_ovr = '0;

    always @(posedge clk or posedge rst) begin
        bit found;
        int k;
        if (rst) begin
            for (int a = 0; a < NK; a++) begin
                for (int p = 0; p < 3; p++) begin
                    m_pend[a][p] = 0;
                    m_det[a][p] = 0;
                end
                m_down[a] = 0;
                m_long[a] = 0;
            end
            m_valid = 0; m_key = 0; m_type = 0; m_ptr = 0; m_ovr = '0;
        end else begin
            m_cyc++;
            // output slot
            if (!m_valid || evt_if.evt_ready_i) begin
                found = 0;
                for (int i = 0; i < NK; i++) begin
                    k = (m_ptr + i) % NK;
                    for (int p = 0; p < 3; p++)
                        if (!found && m_pend[k][p]) begin
                            found = 1; m_key = k; m_type = code[p];
                            m_pend[k][p] = 0; m_ptr = (k + 1) % NK;
                        end
                end
                m_valid = found;
            end
            // events detected last edge become pending now
            if (clr) m_ovr = '0;
            for (int a = 0; a < NK; a++)
                for (int p = 0; p < 3; p++)
                    if (m_det[a][p]) begin
                        if (m_pend[a][p]) m_ovr[a] = 1'b1;
                        m_pend[a][p] = 1;
                    end
            // detect new events from the key inputs
            for (int a = 0; a < NK; a++) begin
                for (int p = 0; p < 3; p++) m_det[a][p] = 0;
                if (!m_down[a]) begin
                    if (tck[a]) begin
                        m_down[a] = 1; m_t0[a] = m_cyc; m_long[a] = 0; m_det[a][0] = 1;
                    end
                end else if (!lvl[a]) begin
                    m_down[a] = 0; m_det[a][2] = 1;
                end
`ifdef LONG_PRESS_EN
                else if (!m_long[a] && (m_cyc - m_t0[a] == HC)) begin
                    m_long[a] = 1; m_det[a][1] = 1;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare + accepted-event log ----------------
    int lg_key[$], lg_typ[$], lg_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", int'(evt_if.evt_valid_o), int'(m_valid));
            if (m_valid) begin
                chk("key", int'(evt_if.evt_key_o), m_key);
                chk("type", int'(evt_if.evt_type_o), m_type);
            end
            chk("overrun", int'(ovr), int'(m_ovr));
            if (evt_if.evt_valid_o && evt_if.evt_ready_i) begin
                lg_key.push_back(int'(evt_if.evt_key_o));
                lg_typ.push_back(int'(evt_if.evt_type_o));
                lg_cyc.push_back(cyc);
            end
        end
    end

    int exp_k[$], exp_t[$];

    task automatic check_log(input string name);
        chk({name, "_count"}, lg_key.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < lg_key.size(); i++) begin
            chk({name, "_key"}, lg_key[i], exp_k[i]);
            chk({name, "_type"}, lg_typ[i], exp_t[i]);
        end
    endtask

    task automatic clear_log();
        lg_key.delete(); lg_typ.delete(); lg_cyc.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic press(input logic [NK-1:0] m);
        tck = m; lvl = lvl | m;
        step(1);
        tck = '0;
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        evt_if.evt_ready_i = 1'b1;
        step(3);
        chk("rst_valid", int'(evt_if.evt_valid_o), 0);
        chk("rst_key", int'(evt_if.evt_key_o), 0);
        chk("rst_type", int'(evt_if.evt_type_o), 0);
        chk("rst_ovr", int'(ovr), 0);
        rst = 1'b0;
        step(2);

        // single tap on key 1
        clear_log(); c0 = cyc;
        press(4'b0010); step(4);
        lvl[1] = 1'b0; step(10);
        exp_k = '{1, 1}; exp_t = '{0, 1};
        check_log("tap");
        if (lg_cyc.size() > 0) chk("tap_latency", lg_cyc[0], c0 + 3);
        chk("tap_ovr", int'(ovr), 0);

        // long hold on key 2
        clear_log(); c0 = cyc;
        press(4'b0100); step(39);
        lvl[2] = 1'b0; step(10);
`ifdef LONG_PRESS_EN
        exp_k = '{2, 2, 2}; exp_t = '{0, 2, 1};
        check_log("long");
        if (lg_cyc.size() > 1) chk("long_latency", lg_cyc[1], c0 + 23);
`else
        exp_k = '{2, 2}; exp_t = '{0, 1};
        check_log("long");
`endif

        // fairness: pointer 0, then pointer 1
        do_reset();
        clear_log();
        press(4'b1001); step(6);
        lvl = '0; step(6);
        press(4'b0001); step(4);
        lvl = '0; step(6);
        press(4'b1001); step(6);
        lvl = '0; step(6);
        exp_k = '{0, 3, 0, 3, 0, 0, 3, 0, 3, 0};
        exp_t = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1};
        check_log("fair");

        // backpressure and overrun on key 0
        do_reset();
        clear_log();
        evt_if.evt_ready_i = 1'b0;
        press(4'b0001); step(3);
        chk("stall_valid", int'(evt_if.evt_valid_o), 1);
        chk("stall_key", int'(evt_if.evt_key_o), 0);
        chk("stall_type", int'(evt_if.evt_type_o), 0);
        lvl = '0; step(3);
        press(4'b0001); step(3);
        lvl = '0; step(4);
        chk("stall_key2", int'(evt_if.evt_key_o), 0);
        chk("stall_type2", int'(evt_if.evt_type_o), 0);
        chk("ovr_set", int'(ovr), 1);
        evt_if.evt_ready_i = 1'b1;
        step(6);
        exp_k = '{0, 0, 0}; exp_t = '{0, 0, 1};
        check_log("drain");
        chk("ovr_sticky", int'(ovr), 1);
        clr = 1'b1; step(1); clr = 1'b0; step(1);
        chk("ovr_clr", int'(ovr), 0);

        // reset while key 1 is pressed and its PRESS is stalled on the channel
        evt_if.evt_ready_i = 1'b0;
        press(4'b0010); step(10);
        rst = 1'b1; #1;
        chk("mid_valid", int'(evt_if.evt_valid_o), 0);
        chk("mid_key", int'(evt_if.evt_key_o), 0);
        chk("mid_type", int'(evt_if.evt_type_o), 0);
        chk("mid_ovr", int'(ovr), 0);
        step(2);
        rst = 1'b0; evt_if.evt_ready_i = 1'b1;
        clear_log();
        step(3);
        lvl[1] = 1'b0; step(10);
        chk("mid_no_evt", lg_key.size(), 0);

        // randomized traffic
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 2500; n++) begin
                for (int a = 0; a < NK; a++) begin
                    tck[a] = 1'b0;
                    if (!lvl[a]) begin
                        int r;
                        r = $urandom_range(0, 99);
                        if (r < 4) begin lvl[a] = 1'b1; tck[a] = 1'b1; end
                        else if (r == 4) lvl[a] = 1'b1;   // rise with no tick
                    end else if ($urandom_range(0, (ph == 0) ? 30 : 8) == 0) begin
                        lvl[a] = 1'b0;
                    end
                end
                evt_if.evt_ready_i = ($urandom_range(0, 99) < ((ph == 0) ? 70 : 20));
                clr = ($urandom_range(0, 63) == 0);
                step(1);
            end
        end
        tck = '0; lvl = '0; clr = 1'b0; evt_if.evt_ready_i = 1'b1;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
